max_exp_stream: RTL and testbench

Streaming, parametrised maximum-exponent finder for the MAC subsystem. Each accepted beat carries LANES exponents with a per-lane skip mask; the block reduces every beat through a registered compare tree and accumulates across beats until `in_last`. It returns one result per group: the group maximum, the lane and beat that produced it, and status flags. It sits between operand unpacking and the alignment shifters, and supports multi-beat (e.g. 3x3xC) windows with valid/ready backpressure.

---
 rtl/max_exp_stream.sv | 161 ++++++++++++++++
 tb/tb_max_exp_stream.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_exp_stream.sv
// Streaming max-exponent finder: input capture, registered compare tree, cross-beat accumulator.
// Latency 2 cycles from closing beat to result; all stages freeze while a result is stalled.
module max_exp_stream #(
   parameter int EXP_W     = 6,
   parameter int LANES     = 9,
   parameter int MAX_BEATS = 16,
   localparam int LANE_W   = $clog2(LANES),
   localparam int BEAT_W   = $clog2(MAX_BEATS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_last,
   input  logic [LANES-1:0]         in_skip,
   input  logic [LANES*EXP_W-1:0]   in_exp,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W-1:0]         out_max_exp,
   output logic [LANE_W-1:0]        out_lane,
   output logic [BEAT_W-1:0]        out_beat,
   output logic                     out_all_skip,
   output logic                     out_overflow
);

   localparam int NP = 1 << LANE_W;

   // Heap-ordered tree; the right child wins only when strictly greater, so ties go to the lower lane.
   function automatic logic [LANE_W+EXP_W-1:0] f_tree(input logic [LANES*EXP_W-1:0] v);
      logic [NP*EXP_W-1:0] vp;
      logic [EXP_W-1:0]    m [2*NP-1];
      logic [LANE_W-1:0]   l [2*NP-1];
      vp = '0;
      vp[LANES*EXP_W-1:0] = v;
      for (int i = 0; i < NP; i++) begin
         m[NP-1+i] = vp[i*EXP_W +: EXP_W];
         l[NP-1+i] = LANE_W'(i);
      end
      for (int k = NP-2; k >= 0; k--) begin
         if (m[2*k+2] > m[2*k+1]) begin
            m[k] = m[2*k+2];
            l[k] = l[2*k+2];
         end else begin
            m[k] = m[2*k+1];
            l[k] = l[2*k+1];
         end
      end
      return {l[0], m[0]};
   endfunction

   logic                   w_adv;
   logic [LANES*EXP_W-1:0] w_vin;
   logic [LANE_W+EXP_W-1:0] w_tree;

   logic [LANES*EXP_W-1:0] r_v;
   logic                   r_s_vld, r_s_any, r_s_last;

   logic [EXP_W-1:0]       r_a_max;
   logic [LANE_W-1:0]      r_a_lane;
   logic                   r_a_vld, r_a_any, r_a_last;

   logic [EXP_W-1:0]       r_acc_max;
   logic [LANE_W-1:0]      r_acc_lane;
   logic [BEAT_W-1:0]      r_acc_beat;
   logic [BEAT_W-1:0]      r_b;
   logic                   r_acc_any, r_acc_empty;

   logic                   r_out_valid, r_out_all_skip, r_out_overflow;
   logic [EXP_W-1:0]       r_out_max;
   logic [LANE_W-1:0]      r_out_lane;
   logic [BEAT_W-1:0]      r_out_beat;

   logic                   w_b_end, w_close, w_take;
   logic [EXP_W-1:0]       w_m_max;
   logic [LANE_W-1:0]      w_m_lane;
   logic [BEAT_W-1:0]      w_m_beat;

   assign w_adv    = !r_out_valid || out_ready;
   assign in_ready = !rst && w_adv;

   always_comb begin
      w_vin = '0;
      for (int i = 0; i < LANES; i++) begin
         w_vin[i*EXP_W +: EXP_W] = in_skip[i] ? '0 : in_exp[i*EXP_W +: EXP_W];
      end
   end

   assign w_tree = f_tree(r_v);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s_vld <= 1'b0;
         r_a_vld <= 1'b0;
      end else if (w_adv) begin
         r_s_vld <= in_valid;
         if (in_valid) begin
            r_v      <= w_vin;
            r_s_any  <= |(~in_skip);
            r_s_last <= in_last;
         end
         r_a_vld <= r_s_vld;
         if (r_s_vld) begin
            {r_a_lane, r_a_max} <= w_tree;
            r_a_any             <= r_s_any;
            r_a_last            <= r_s_last;
         end
      end
   end

   // A later beat replaces the running best only when strictly larger, keeping the earliest beat on ties.
   assign w_b_end  = (r_b == BEAT_W'(MAX_BEATS-1));
   assign w_close  = r_a_vld && (r_a_last || w_b_end);
   assign w_take   = r_acc_empty || (r_a_max > r_acc_max);
   assign w_m_max  = w_take ? r_a_max  : r_acc_max;
   assign w_m_lane = w_take ? r_a_lane : r_acc_lane;
   assign w_m_beat = w_take ? r_b      : r_acc_beat;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_b            <= '0;
         r_acc_empty    <= 1'b1;
         r_acc_any      <= 1'b0;
         r_acc_max      <= '0;
         r_acc_lane     <= '0;
         r_acc_beat     <= '0;
         r_out_valid    <= 1'b0;
         r_out_max      <= '0;
         r_out_lane     <= '0;
         r_out_beat     <= '0;
         r_out_all_skip <= 1'b0;
         r_out_overflow <= 1'b0;
      end else if (w_adv) begin
         r_out_valid <= w_close;
         if (w_close) begin
            r_out_max      <= w_m_max;
            r_out_lane     <= w_m_lane;
            r_out_beat     <= w_m_beat;
            r_out_all_skip <= !(r_acc_any || r_a_any);
            r_out_overflow <= w_b_end && !r_a_last;
            r_b            <= '0;
            r_acc_empty    <= 1'b1;
            r_acc_any      <= 1'b0;
         end else if (r_a_vld) begin
            r_acc_max   <= w_m_max;
            r_acc_lane  <= w_m_lane;
            r_acc_beat  <= w_m_beat;
            r_acc_any   <= r_acc_any || r_a_any;
            r_b         <= r_b + 1'b1;
            r_acc_empty <= 1'b0;
         end
      end
   end

   assign out_valid    = r_out_valid;
   assign out_max_exp  = r_out_max;
   assign out_lane     = r_out_lane;
   assign out_beat     = r_out_beat;
   assign out_all_skip = r_out_all_skip;
   assign out_overflow = r_out_overflow;

endmodule

// File: tb/tb_max_exp_stream.sv
// Bench for max_exp_stream: directed groups plus random beats against a group-level reference model.
module tb_max_exp_stream;

   localparam int EXP_W = 6, LANES = 9, MAX_BEATS = 4, LANE_W = 4, BEAT_W = 2;

   logic                   clk = 1'b0, rst = 1'b1;
   logic                   in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
   logic [LANES-1:0]       in_skip = '0;
   logic [LANES*EXP_W-1:0] in_exp = '0;
   logic                   in_ready, out_valid, out_all_skip, out_overflow;
   logic [EXP_W-1:0]       out_max_exp;
   logic [LANE_W-1:0]      out_lane;
   logic [BEAT_W-1:0]      out_beat;

   max_exp_stream #(.EXP_W(EXP_W), .LANES(LANES), .MAX_BEATS(MAX_BEATS)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .in_skip(in_skip), .in_exp(in_exp), .out_valid(out_valid), .out_ready(out_ready),
      .out_max_exp(out_max_exp), .out_lane(out_lane), .out_beat(out_beat),
      .out_all_skip(out_all_skip), .out_overflow(out_overflow));

   always #5 clk = ~clk;

   int n_checks = 0, n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference model: a group's result is the first occurrence of its maximum in beat-major, lane-minor order.
   typedef struct { int mx; int lane; int beat; int askip; int ovf; } res_t;
   res_t exp_q[$];
   int   cur_n = 0, best_v = 0, best_l = 0, best_b = 0;
   bit   cur_any = 0;

   function automatic void model_beat(input logic [LANES*EXP_W-1:0] e, input logic [LANES-1:0] s,
                                      input logic l);
      res_t r;
      for (int i = 0; i < LANES; i++) begin
         int v;
         v = s[i] ? 0 : int'(e[i*EXP_W +: EXP_W]);
         if ((cur_n == 0 && i == 0) || v > best_v) begin
            best_v = v; best_l = i; best_b = cur_n;
         end
         if (!s[i]) cur_any = 1;
      end
      cur_n++;
      if (l || cur_n == MAX_BEATS) begin
         r.mx = best_v; r.lane = best_l; r.beat = best_b;
         r.askip = cur_any ? 0 : 1;
         r.ovf = l ? 0 : 1;
         exp_q.push_back(r);
         cur_n = 0;
         cur_any = 0;
      end
   endfunction

   function automatic logic [LANES*EXP_W-1:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
      int t[9];
      logic [LANES*EXP_W-1:0] e;
      t = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
      for (int i = 0; i < LANES; i++) e[i*EXP_W +: EXP_W] = EXP_W'(t[i]);
      return e;
   endfunction

   // Output monitor, sampled mid-low-phase after all bench drives have settled.
   int   res_cnt = 0, got_mx, got_lane, got_beat, got_askip, got_ovf;
   bit   prev_stall = 0;
   logic [13:0] snap;
   res_t e_r;

   always begin
      @(negedge clk);
      #3;
      if (rst) begin
         chk("in_ready_rst", in_ready, 0);
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            chk("stall_hold_vld", out_valid, 1);
            chk("stall_stable", {out_max_exp, out_lane, out_beat, out_all_skip, out_overflow}, snap);
         end
         chk("in_ready", in_ready, (!out_valid || out_ready) ? 1 : 0);
         if (out_valid && out_ready) begin
            chk("result_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e_r = exp_q.pop_front();
               chk("res_max", out_max_exp, e_r.mx);
               chk("res_lane", out_lane, e_r.lane);
               chk("res_beat", out_beat, e_r.beat);
               chk("res_askip", out_all_skip, e_r.askip);
               chk("res_ovf", out_overflow, e_r.ovf);
            end
            got_mx = out_max_exp; got_lane = out_lane; got_beat = out_beat;
            got_askip = out_all_skip; got_ovf = out_overflow;
            res_cnt++;
         end
         prev_stall = out_valid && !out_ready;
         snap = {out_max_exp, out_lane, out_beat, out_all_skip, out_overflow};
      end
   end

   task automatic send_beat(input logic [LANES*EXP_W-1:0] e, input logic [LANES-1:0] s, input logic l);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1; in_exp = e; in_skip = s; in_last = l;
      #2;
      while (!in_ready && n < 300) begin
         @(negedge clk);
         #2;
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", in_ready, 1);
         in_valid = 1'b0;
      end else begin
         model_beat(e, s, l);
         @(posedge clk);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      in_exp = {$urandom, $urandom};
      in_skip = LANES'($urandom);
      in_last = 1'($urandom);
   endtask

   task automatic wait_res(input int target);
      int n = 0;
      while (res_cnt < target && n < 300) begin
         @(posedge clk);
         n++;
      end
      chk("result_timeout", res_cnt >= target, 1);
   endtask

   task automatic chk_res(input string tag, input int mx, lane, beat, askip, ovf);
      chk({tag, "_max"}, got_mx, mx);
      chk({tag, "_lane"}, got_lane, lane);
      chk({tag, "_beat"}, got_beat, beat);
      chk({tag, "_askip"}, got_askip, askip);
      chk({tag, "_ovf"}, got_ovf, ovf);
   endtask

   int  r0;
   bit  rnd_done;

   initial begin
      repeat (3) @(negedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_fields", {out_max_exp, out_lane, out_beat, out_all_skip, out_overflow}, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);

      // single beat: latency and lowest-lane tie break
      r0 = res_cnt;
      send_beat(pk(3, 17, 5, 17, 0, 9, 1, 2, 4), 9'h000, 1'b1);
      @(negedge clk); in_valid = 1'b0; #1;
      chk("lat_e0", out_valid, 0);
      @(negedge clk); #1;
      chk("lat_e1", out_valid, 0);
      @(negedge clk); #1;
      chk("lat_e2", out_valid, 1);
      wait_res(r0 + 1);
      chk_res("single", 17, 1, 0, 0, 0);

      r0 = res_cnt;
      send_beat(pk(3, 17, 5, 17, 0, 9, 1, 2, 4), 9'b000001010, 1'b1);
      idle();
      wait_res(r0 + 1);
      chk_res("skip13", 9, 5, 0, 0, 0);

      r0 = res_cnt;
      send_beat(pk(1, 2, 20, 3, 4, 5, 6, 7, 8), 9'h000, 1'b0);
      send_beat(pk(10, 11, 12, 13, 14, 15, 16, 17, 31), 9'h000, 1'b0);
      send_beat(pk(31, 0, 1, 2, 3, 4, 5, 6, 7), 9'h000, 1'b1);
      idle();
      wait_res(r0 + 1);
      chk_res("beat_tie", 31, 8, 1, 0, 0);

      r0 = res_cnt;
      send_beat(pk(5, 6, 7, 8, 9, 10, 11, 12, 13), 9'h1FF, 1'b0);
      send_beat(pk(60, 61, 62, 63, 1, 2, 3, 4, 5), 9'h1FF, 1'b1);
      idle();
      wait_res(r0 + 1);
      chk_res("all_skip", 0, 0, 0, 1, 0);

      r0 = res_cnt;
      send_beat(pk(1, 2, 3, 4, 5, 6, 7, 8, 9), 9'h000, 1'b0);
      send_beat(pk(10, 11, 12, 13, 14, 15, 16, 17, 18), 9'h000, 1'b0);
      send_beat(pk(20, 1, 1, 1, 1, 1, 1, 1, 1), 9'h000, 1'b0);
      send_beat(pk(0, 0, 0, 0, 40, 39, 0, 0, 0), 9'h000, 1'b0);
      send_beat(pk(50, 1, 1, 1, 1, 1, 1, 1, 1), 9'h000, 1'b0);
      idle();
      wait_res(r0 + 1);
      chk_res("overflow", 40, 4, 3, 0, 1);
      send_beat(pk(2, 2, 2, 2, 2, 2, 2, 2, 2), 9'h000, 1'b1);
      idle();
      wait_res(r0 + 2);
      chk_res("after_ovf", 50, 0, 0, 0, 0);

      // back-to-back groups against a stalled consumer
      r0 = res_cnt;
      @(negedge clk);
      out_ready = 1'b0;
      fork
         begin
            send_beat(pk(1, 2, 3, 11, 4, 5, 6, 7, 8), 9'h000, 1'b1);
            send_beat(pk(1, 2, 3, 4, 5, 6, 7, 22, 8), 9'h000, 1'b1);
            send_beat(pk(33, 2, 3, 4, 5, 6, 7, 8, 9), 9'h000, 1'b1);
            idle();
         end
         begin
            int n = 0;
            while (!out_valid && n < 100) begin
               @(negedge clk);
               n++;
            end
            #2;
            chk("stall_vld_seen", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            repeat (5) @(negedge clk);
            repeat (12) begin
               @(negedge clk); out_ready = 1'b1;
               @(negedge clk); out_ready = 1'b0;
            end
            @(negedge clk); out_ready = 1'b1;
         end
      join
      wait_res(r0 + 3);
      chk_res("stall_last", 33, 0, 0, 0, 0);

      // reset mid-group discards the partial group
      send_beat(pk(60, 1, 1, 1, 1, 1, 1, 1, 1), 9'h000, 1'b0);
      send_beat(pk(61, 1, 1, 1, 1, 1, 1, 1, 1), 9'h000, 1'b0);
      idle();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      cur_n = 0;
      cur_any = 0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_vld", out_valid, 0);
      r0 = res_cnt;
      send_beat(pk(0, 7, 0, 3, 0, 0, 1, 0, 0), 9'h000, 1'b1);
      idle();
      wait_res(r0 + 1);
      chk_res("post_rst", 7, 1, 0, 0, 0);
      repeat (6) @(negedge clk);
      chk("post_rst_count", res_cnt, r0 + 1);

      // random beats with random consumer backpressure
      rnd_done = 0;
      fork
         begin
            for (int k = 0; k < 150; k++) begin
               logic [LANES*EXP_W-1:0] e;
               logic [LANES-1:0] s;
               int lim;
               lim = ($urandom_range(0, 1) == 0) ? 15 : 63;
               for (int i = 0; i < LANES; i++) e[i*EXP_W +: EXP_W] = EXP_W'($urandom_range(0, lim));
               s = LANES'($urandom & $urandom);
               if ($urandom_range(0, 9) == 0) s = '1;
               send_beat(e, s, $urandom_range(0, 2) == 0);
               if ($urandom_range(0, 3) == 0) idle();
            end
            send_beat(pk(1, 1, 1, 1, 1, 1, 1, 1, 1), 9'h000, 1'b1);
            idle();
            rnd_done = 1;
         end
         begin
            while (!rnd_done) begin
               @(negedge clk);
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join

      begin
         int n = 0;
         while (exp_q.size() > 0 && n < 300) begin
            @(posedge clk);
            n++;
         end
      end
      repeat (2) @(negedge clk);
      chk("drain", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
